// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter sequencer.
package pc_pkg;

  // Source of the next fetch address, in priority order from low to high.
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_RET = 2'd3
  } next_pc_sel_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int unsigned DEFAULT_SHIFT    = 2;

  // Byte distance between consecutive instructions for a given shift.
  function automatic int unsigned pc_step(input int unsigned shift);
    return 32'd1 << shift;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack. A push on a full stack overwrites
// the oldest entry; the entry count saturates at RAS_DEPTH. A pop on an
// empty stack changes nothing. Push and pop together replace the top entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   top_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;
  logic            do_swap;

  assign top_ptr = wr_ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);

  assign do_swap = push & pop & ~empty;
  assign do_push = push & ~do_swap;
  assign do_pop  = pop & ~push & ~empty;

  // Entry storage: no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_swap) begin
      mem[top_ptr] <= push_data;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Write pointer and saturating occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != CW'(RAS_DEPTH)) begin
        count <= count + 1'b1;
      end
    end else if (do_pop) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with sequential / branch / jump / return
// next-PC selection. Optional return-address stack enabled by PC_RAS_EN.
//
// Fetch handshake: pc_valid is the producer's valid, fetch_ready the
// consumer's ready. A transfer (fire) happens on a rising edge where both are
// 1; only then are the control inputs sampled and the PC advanced. Without a
// fire, pc, redirect and the stack hold, and the requester holds its inputs.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              IMM_W     = 16,
  parameter int              SHIFT     = DEFAULT_SHIFT,
  parameter int              JIDX_W    = 26,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_ready,
  input  logic              branch_req,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  imm,
  input  logic              jump_req,
  input  logic [JIDX_W-1:0] jump_idx,
  input  logic              call,
  input  logic              ret,
  input  logic [XLEN-1:0]   ras_target,
  output logic [XLEN-1:0]   pc,
  output logic              pc_valid,
  output logic [XLEN-1:0]   pc_plus,
  output logic              redirect,
  output logic              ras_underflow
);

  localparam logic [XLEN-1:0] STEP = XLEN'(pc_step(SHIFT));

  logic            fire;
  next_pc_sel_t    sel;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] jmp_pc;
  logic [XLEN-1:0] ret_pc;
  logic            ret_eff;
  logic            underflow_now;

  assign fire    = pc_valid & fetch_ready;
  assign pc_plus = pc + STEP;
  assign br_off  = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm} << SHIFT;
  assign br_pc   = pc_plus + br_off;
  // Jump keeps the region bits of the sequential address.
  assign jmp_pc  = {pc_plus[XLEN-1:JIDX_W+SHIFT], jump_idx, {SHIFT{1'b0}}};

`ifdef PC_RAS_EN
  logic            push;
  logic            pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  // ret outranks a simultaneous call, so a call only pushes when ret is low.
  assign ret_eff       = ret;
  assign push          = fire & jump_req & call & ~ret;
  assign pop           = fire & ret;
  assign ret_pc        = ras_empty ? ras_target : ras_top;
  assign underflow_now = ret & ras_empty;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;

  // No stack: ret and call have no effect and ret falls through the chain.
  assign ret_eff       = 1'b0;
  assign ret_pc        = '0;
  assign underflow_now = 1'b0;
  assign unused_ras    = ^{ret, call, ras_target};
`endif

  // Next-PC priority: ret > jump > taken branch > sequential.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus;
    if (ret_eff) begin
      sel     = SEL_RET;
      next_pc = ret_pc;
    end else if (jump_req) begin
      sel     = SEL_JMP;
      next_pc = jmp_pc;
    end else if (branch_req && branch_taken) begin
      sel     = SEL_BR;
      next_pc = br_pc;
    end
  end

  // PC register, valid flag, redirect flag and underflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      pc_valid      <= 1'b0;
      redirect      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_valid      <= 1'b1;
      ras_underflow <= 1'b0;
      if (fire) begin
        pc            <= next_pc;
        redirect      <= (sel != SEL_SEQ);
        ras_underflow <= underflow_now;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus random traffic checked every cycle
// against a behavioural model (queue-based return stack).
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        branch_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm = '0;
  logic        jump_req = 1'b0;
  logic [25:0] jump_idx = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] ras_target = '0;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_plus;
  logic        redirect;
  logic        ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_redir;
  logic        m_uflow;
  logic [31:0] m_stk[$];

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_ready   (fetch_ready),
    .branch_req    (branch_req),
    .branch_taken  (branch_taken),
    .imm           (imm),
    .jump_req      (jump_req),
    .jump_idx      (jump_idx),
    .call          (call),
    .ret           (ret),
    .ras_target    (ras_target),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pc_plus       (pc_plus),
    .redirect      (redirect),
    .ras_underflow (ras_underflow)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_valid = 1'b0;
    m_redir = 1'b0;
    m_uflow = 1'b0;
    m_stk.delete();
  endtask

  // One rising edge of the reference model, using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] seq, tgt;
    logic        rd, uf;
    int          off;
    if (!m_valid || !fetch_ready) begin
      m_valid = 1'b1;
      m_uflow = 1'b0;
      return;
    end
    seq = m_pc + 32'd4;
    tgt = seq;
    rd  = 1'b0;
    uf  = 1'b0;
    if (RAS_ON && ret) begin
      rd = 1'b1;
      if (m_stk.size() > 0) tgt = m_stk.pop_back();
      else begin
        tgt = ras_target;
        uf  = 1'b1;
      end
    end else if (jump_req) begin
      rd  = 1'b1;
      tgt = (seq & 32'hF000_0000) | ({6'b0, jump_idx} * 32'd4);
      if (RAS_ON && call) begin
        m_stk.push_back(seq);
        if (m_stk.size() > 4) void'(m_stk.pop_front());
      end
    end else if (branch_req && branch_taken) begin
      rd  = 1'b1;
      off = $signed(imm);
      tgt = seq + 32'(off * 4);
    end
    m_pc    = tgt;
    m_redir = rd;
    m_uflow = uf;
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_valid", pc_valid, m_valid);
    check("pc_plus", pc_plus, m_pc + 32'd4);
    check("redirect", redirect, m_redir);
    check("ras_underflow", ras_underflow, m_uflow);
  endtask

  // Driver: apply one set of inputs (called at the falling edge).
  task automatic drive(input logic fr, input logic br, input logic tk, input logic [15:0] im,
                       input logic jr, input logic [25:0] ji, input logic cl, input logic rt);
    fetch_ready  = fr;
    branch_req   = br;
    branch_taken = tk;
    imm          = im;
    jump_req     = jr;
    jump_idx     = ji;
    call         = cl;
    ret          = rt;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b0);
  endtask

  // One clock: edge, model update, compare at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a[5];
    logic [31:0] p, exp_v;
    int hops;

    // Reset
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    check("first_valid", pc_valid, 1'b0);

    // Sequential start
    cyc(); check("tp_seq0", pc, 32'h0040_0000); check("tp_valid", pc_valid, 1'b1);
    cyc(); check("tp_seq1", pc, 32'h0040_0004);
    cyc(); check("tp_seq2", pc, 32'h0040_0008); check("tp_seq_redir", redirect, 1'b0);
    cyc(); cyc();

    // Branches at 0x0040_0010
    drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 1'b0);
    cyc(); check("tp_br_back", pc, 32'h0040_0010); check("tp_br_redir", redirect, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 1'b0);
    cyc(); check("tp_br_fwd", pc, 32'h0040_0020);
    drive(1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 26'h0, 1'b0, 1'b0);
    cyc(); check("tp_br_nt", pc, 32'h0040_0024); check("tp_nt_redir", redirect, 1'b0);

    // Stall with jump held, then fire
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h010_0040, 1'b0, 1'b0);
    repeat (3) cyc();
    check("tp_stall_pc", pc, 32'h0040_0024); check("tp_stall_redir", redirect, 1'b0);
    fetch_ready = 1'b1;
    cyc(); check("tp_jump", pc, 32'h0040_0100);

    // Call / return
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h010_0008, 1'b0, 1'b0);
    cyc(); check("tp_jmp20", pc, 32'h0040_0020);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h010_0040, 1'b1, 1'b0);
    cyc(); check("tp_call", pc, 32'h0040_0100);
    idle(); cyc(); cyc();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b1);
    cyc(); check("tp_ret", pc, RAS_ON ? 32'h0040_0024 : 32'h0040_010C);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h010_0080, 1'b1, 1'b0);
    p = pc;
    cyc(); check("tp_call2", pc, 32'h0040_0200);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h010_0100, 1'b1, 1'b1);
    cyc(); check("tp_ret_wins", pc, RAS_ON ? p + 32'd4 : 32'h0040_0400);

    // Five calls then five rets on a four-deep stack
    ras_target = 32'h0012_3450;
    for (int i = 0; i < 5; i++) begin
      a[i] = m_pc;
      drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h010_0400 + 26'(i * 64), 1'b1, 1'b0);
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      p = m_pc;
      drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b1);
      cyc();
      if (RAS_ON) exp_v = (i < 4) ? a[4-i] + 32'd4 : 32'h0012_3450;
      else exp_v = p + 32'd4;
      check("tp_ret_chain", pc, exp_v);
      check("tp_uflow", ras_underflow, (RAS_ON && i == 4) ? 1'b1 : 1'b0);
    end
    idle(); cyc(); check("tp_uflow_pulse", ras_underflow, 1'b0);

    // Walk backwards with large branches until the address wraps
    hops = 0;
    drive(1'b1, 1'b1, 1'b1, 16'h8000, 1'b0, 26'h0, 1'b0, 1'b0);
    while (m_pc >= 32'h0002_0000 && hops < 64) begin
      cyc();
      hops++;
    end
    cyc();
    check("wrap_hops_bounded", (hops < 64) ? 32'd1 : 32'd0, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFF, 1'b0, 1'b0);
    cyc(); check("tp_top_pc", pc, 32'hFFFF_FFFC); check("tp_top_plus", pc_plus, 32'h0000_0000);
    idle();
    cyc(); check("tp_wrap", pc, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      fetch_ready  = ($urandom_range(0, 9) < 8);
      branch_req   = $urandom_range(0, 1);
      branch_taken = $urandom_range(0, 1);
      imm          = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15) - 8);
      jump_req     = ($urandom_range(0, 4) == 0);
      jump_idx     = 26'($urandom);
      call         = $urandom_range(0, 1);
      ret          = ($urandom_range(0, 5) == 0);
      ras_target   = $urandom;
      cyc();
    end

    // Asynchronous reset in the middle of a branch
    drive(1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 26'h0, 1'b0, 1'b0);
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_pc", pc, RST_PC);
    check("async_valid", pc_valid, 1'b0);
    check("async_redir", redirect, 1'b0);
    check("async_uflow", ras_underflow, 1'b0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle();
    cyc(); cyc();
    ras_target = 32'hABCD_0000;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b1);
    cyc();
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
